// File: rtl/game_pkg.sv
// Shared types and constants for the foosball match sequencer.
// Goal codes double as winner codes: 01 = our side, 10 = opponent.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    GOAL_PULSE,
    CELEBRATE,
    RESET_BALL,
    KICKOFF,
    GAME_OVER
  } match_state_t;

  localparam logic [1:0] GOAL_OURS = 2'b01;
  localparam logic [1:0] GOAL_OPP  = 2'b10;
  localparam logic [1:0] GOAL_NONE = 2'b00;

  // Simultaneous detection on both sides (11) is treated as noise, not a goal.
  function automatic logic is_goal(input logic [1:0] g);
    return (g == GOAL_OURS) || (g == GOAL_OPP);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick counter shared by the celebration pause and the kickoff countdown.
// Held at zero while disabled; saturates at 'last' instead of wrapping.
module frame_timer #(
  parameter int CTR_W = 7
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             enable,
  input  logic             tick,
  input  logic [CTR_W-1:0] last,
  output logic             done
);

  logic [CTR_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_reg <= '0;
    end else if (!enable) begin
      cnt_reg <= '0;
    end else if (tick && (cnt_reg != last)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // The frame that lands on 'last' completes the interval, so N=1 means one frame.
  assign done = enable && tick && (cnt_reg == last);

endmodule

// File: rtl/match_flow_ctrl.sv
// Match flow sequencer: goal pulses, celebration freeze, ball re-spawn,
// kickoff countdown and game-over detection. All outputs are registered.
module match_flow_ctrl
  import game_pkg::*;
#(
  parameter int PAUSE_FRAMES   = 120,
  parameter int KICKOFF_FRAMES = 30,
  parameter int WIN_SCORE      = 5,
  parameter int SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startBtn,
  input  logic [1:0]         goalDetect,
  input  logic [SCORE_W-1:0] ourScore,
  input  logic [SCORE_W-1:0] oppScore,
  output logic [1:0]         goalWasScored,
  output logic               freezePlay,
  output logic               ballResetN,
  output logic               celebrate,
  output logic               gameOver,
  output logic [1:0]         winner
);

  localparam int CTR_W = $clog2(max_int(PAUSE_FRAMES, KICKOFF_FRAMES) + 1);
  localparam logic [CTR_W-1:0]   PAUSE_LAST   = CTR_W'(PAUSE_FRAMES - 1);
  localparam logic [CTR_W-1:0]   KICKOFF_LAST = CTR_W'(KICKOFF_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_LEVEL    = SCORE_W'(WIN_SCORE);

  match_state_t     state_reg;
  logic [1:0]       captured_reg;
  logic             freeze_reg;
  logic             ball_reset_n_reg;
  logic             celebrate_reg;
  logic             game_over_reg;
  logic [1:0]       winner_reg;

  logic             timer_enable;
  logic [CTR_W-1:0] timer_last;
  logic             timer_done;

  // Leaving a timed state always passes through an untimed one, which clears the count.
  assign timer_enable = (state_reg == CELEBRATE) || (state_reg == KICKOFF);
  assign timer_last   = (state_reg == CELEBRATE) ? PAUSE_LAST : KICKOFF_LAST;

  frame_timer #(
    .CTR_W (CTR_W)
  ) u_frame_timer (
    .clk    (clk),
    .resetN (resetN),
    .enable (timer_enable),
    .tick   (startOfFrame),
    .last   (timer_last),
    .done   (timer_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg        <= IDLE;
      captured_reg     <= GOAL_NONE;
      freeze_reg       <= 1'b1;
      ball_reset_n_reg <= 1'b1;
      celebrate_reg    <= 1'b0;
      game_over_reg    <= 1'b0;
      winner_reg       <= GOAL_NONE;
    end else begin
      ball_reset_n_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          freeze_reg <= 1'b1;
          if (startBtn) begin
            state_reg        <= RESET_BALL;
            ball_reset_n_reg <= 1'b0;
          end
        end
        RESET_BALL: begin
          state_reg <= KICKOFF;
        end
        KICKOFF: begin
          if (timer_done) begin
            state_reg  <= PLAY;
            freeze_reg <= 1'b0;
          end
        end
        PLAY: begin
          // The captured code is itself the one-cycle pulse to the score block.
          if (is_goal(goalDetect)) begin
            state_reg    <= GOAL_PULSE;
            captured_reg <= goalDetect;
            freeze_reg   <= 1'b1;
          end
        end
        GOAL_PULSE: begin
          state_reg     <= CELEBRATE;
          captured_reg  <= GOAL_NONE;
          celebrate_reg <= 1'b1;
        end
        CELEBRATE: begin
          if (timer_done) begin
            celebrate_reg <= 1'b0;
            if (ourScore >= WIN_LEVEL) begin
              state_reg     <= GAME_OVER;
              game_over_reg <= 1'b1;
              winner_reg    <= GOAL_OURS;
            end else if (oppScore >= WIN_LEVEL) begin
              state_reg     <= GAME_OVER;
              game_over_reg <= 1'b1;
              winner_reg    <= GOAL_OPP;
            end else begin
              state_reg        <= RESET_BALL;
              ball_reset_n_reg <= 1'b0;
            end
          end
        end
        GAME_OVER: begin
          freeze_reg    <= 1'b1;
          game_over_reg <= 1'b1;
        end
        default: begin
          state_reg     <= IDLE;
          captured_reg  <= GOAL_NONE;
          freeze_reg    <= 1'b1;
          celebrate_reg <= 1'b0;
          game_over_reg <= 1'b0;
          winner_reg    <= GOAL_NONE;
        end
      endcase
    end
  end

  assign goalWasScored = captured_reg;
  assign freezePlay    = freeze_reg;
  assign ballResetN    = ball_reset_n_reg;
  assign celebrate     = celebrate_reg;
  assign gameOver      = game_over_reg;
  assign winner        = winner_reg;

endmodule

// File: tb/tb_match_flow_ctrl.sv
// Directed testbench for match_flow_ctrl using the default frame counts.
// Each frame is two clocks: one with startOfFrame high, one idle.
module tb_match_flow_ctrl;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       startBtn;
  logic [1:0] goalDetect;
  logic [7:0] ourScore;
  logic [7:0] oppScore;
  logic [1:0] goalWasScored;
  logic       freezePlay;
  logic       ballResetN;
  logic       celebrate;
  logic       gameOver;
  logic [1:0] winner;

  int checks;
  int errors;
  int brn_lows;
  int ours_pulses;
  int opp_pulses;

  match_flow_ctrl dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .startBtn      (startBtn),
    .goalDetect    (goalDetect),
    .ourScore      (ourScore),
    .oppScore      (oppScore),
    .goalWasScored (goalWasScored),
    .freezePlay    (freezePlay),
    .ballResetN    (ballResetN),
    .celebrate     (celebrate),
    .gameOver      (gameOver),
    .winner        (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the edge, tallying pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (!ballResetN) brn_lows++;
    if (goalWasScored == 2'b01) ours_pulses++;
    if (goalWasScored == 2'b10) opp_pulses++;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic clear_counts();
    brn_lows    = 0;
    ours_pulses = 0;
    opp_pulses  = 0;
  endtask

  task automatic start_match();
    startBtn = 1'b1;
    cyc();
    startBtn = 1'b0;
    cyc();
    frames(30);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    cyc();
    cyc();
    checks++; if (goalWasScored !== 2'b00) begin errors++; $display("FAIL reset_goal: got %b want 00", goalWasScored); end
    checks++; if (freezePlay !== 1'b1) begin errors++; $display("FAIL reset_freeze: got %b want 1", freezePlay); end
    checks++; if (ballResetN !== 1'b1) begin errors++; $display("FAIL reset_ballResetN: got %b want 1", ballResetN); end
    checks++; if (celebrate !== 1'b0) begin errors++; $display("FAIL reset_celebrate: got %b want 0", celebrate); end
    checks++; if (gameOver !== 1'b0) begin errors++; $display("FAIL reset_gameOver: got %b want 0", gameOver); end
    checks++; if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner: got %b want 00", winner); end
    resetN = 1'b1;
    repeat (3) cyc();
    checks++; if (freezePlay !== 1'b1) begin errors++; $display("FAIL idle_freeze: got %b want 1", freezePlay); end
    $display("test_reset done");
  endtask

  task automatic test_start();
    clear_counts();
    startBtn = 1'b1;
    cyc();
    checks++; if (ballResetN !== 1'b0) begin errors++; $display("FAIL start_ballResetN_low: got %b want 0", ballResetN); end
    cyc();
    checks++; if (ballResetN !== 1'b1) begin errors++; $display("FAIL start_ballResetN_release: got %b want 1", ballResetN); end
    frames(29);
    checks++; if (freezePlay !== 1'b1) begin errors++; $display("FAIL kickoff_29_freeze: got %b want 1", freezePlay); end
    frame();
    checks++; if (freezePlay !== 1'b0) begin errors++; $display("FAIL kickoff_30_play: got %b want 0", freezePlay); end
    checks++; if (brn_lows !== 1) begin errors++; $display("FAIL start_held_single_respawn: got %0d want 1", brn_lows); end
    startBtn = 1'b0;
    $display("test_start done");
  endtask

  task automatic test_no_goal_11();
    clear_counts();
    goalDetect = 2'b11;
    repeat (5) cyc();
    goalDetect = 2'b00;
    checks++; if (ours_pulses + opp_pulses !== 0) begin errors++; $display("FAIL both_goal_pulses: got %0d want 0", ours_pulses + opp_pulses); end
    checks++; if (freezePlay !== 1'b0) begin errors++; $display("FAIL both_goal_still_play: got %b want 0", freezePlay); end
    $display("test_no_goal_11 done");
  endtask

  task automatic test_goal_ours();
    clear_counts();
    goalDetect = 2'b01;
    cyc();
    checks++; if (goalWasScored !== 2'b01) begin errors++; $display("FAIL goal_pulse: got %b want 01", goalWasScored); end
    checks++; if (freezePlay !== 1'b1) begin errors++; $display("FAIL goal_freeze: got %b want 1", freezePlay); end
    cyc();
    checks++; if (goalWasScored !== 2'b00) begin errors++; $display("FAIL goal_pulse_end: got %b want 00", goalWasScored); end
    checks++; if (celebrate !== 1'b1) begin errors++; $display("FAIL celebrate_on: got %b want 1", celebrate); end
    repeat (8) cyc();
    goalDetect = 2'b00;
    repeat (300) cyc();
    checks++; if (celebrate !== 1'b1) begin errors++; $display("FAIL no_tick_hold: got %b want 1", celebrate); end
    goalDetect = 2'b10;
    frames(119);
    checks++; if (celebrate !== 1'b1) begin errors++; $display("FAIL celebrate_119: got %b want 1", celebrate); end
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    checks++; if (ballResetN !== 1'b0) begin errors++; $display("FAIL respawn_low: got %b want 0", ballResetN); end
    checks++; if (celebrate !== 1'b0) begin errors++; $display("FAIL celebrate_off: got %b want 0", celebrate); end
    cyc();
    checks++; if (ballResetN !== 1'b1) begin errors++; $display("FAIL respawn_release: got %b want 1", ballResetN); end
    frames(29);
    checks++; if (freezePlay !== 1'b1) begin errors++; $display("FAIL kickoff2_29_freeze: got %b want 1", freezePlay); end
    goalDetect = 2'b00;
    frame();
    checks++; if (freezePlay !== 1'b0) begin errors++; $display("FAIL kickoff2_play: got %b want 0", freezePlay); end
    checks++; if (ours_pulses !== 1) begin errors++; $display("FAIL held_goal_single_pulse: got %0d want 1", ours_pulses); end
    checks++; if (opp_pulses !== 0) begin errors++; $display("FAIL goal_outside_play: got %0d want 0", opp_pulses); end
    checks++; if (brn_lows !== 1) begin errors++; $display("FAIL respawn_count: got %0d want 1", brn_lows); end
    $display("test_goal_ours done");
  endtask

  task automatic test_game_over_opp();
    oppScore = 8'd5;
    goalDetect = 2'b10;
    cyc();
    checks++; if (goalWasScored !== 2'b10) begin errors++; $display("FAIL opp_pulse: got %b want 10", goalWasScored); end
    goalDetect = 2'b00;
    cyc();
    frames(119);
    checks++; if (gameOver !== 1'b0) begin errors++; $display("FAIL gameover_early: got %b want 0", gameOver); end
    frame();
    checks++; if (gameOver !== 1'b1) begin errors++; $display("FAIL gameover_set: got %b want 1", gameOver); end
    checks++; if (winner !== 2'b10) begin errors++; $display("FAIL winner_opp: got %b want 10", winner); end
    checks++; if (celebrate !== 1'b0) begin errors++; $display("FAIL gameover_celebrate: got %b want 0", celebrate); end
    checks++; if (freezePlay !== 1'b1) begin errors++; $display("FAIL gameover_freeze: got %b want 1", freezePlay); end
    clear_counts();
    goalDetect = 2'b01;
    startBtn = 1'b1;
    frames(40);
    goalDetect = 2'b00;
    startBtn = 1'b0;
    checks++; if (ours_pulses + brn_lows !== 0) begin errors++; $display("FAIL gameover_absorbing_events: got %0d want 0", ours_pulses + brn_lows); end
    checks++; if (gameOver !== 1'b1 || winner !== 2'b10) begin errors++; $display("FAIL gameover_held: got %b/%b want 1/10", gameOver, winner); end
    $display("test_game_over_opp done");
  endtask

  task automatic test_async_reset();
    #2 resetN = 1'b0;
    #1;
    checks++; if (gameOver !== 1'b0 || winner !== 2'b00) begin errors++; $display("FAIL async_from_gameover: got %b/%b want 0/00", gameOver, winner); end
    oppScore = 8'd0;
    cyc();
    resetN = 1'b1;
    cyc();
    start_match();
    goalDetect = 2'b01;
    cyc();
    goalDetect = 2'b00;
    cyc();
    frames(10);
    checks++; if (celebrate !== 1'b1) begin errors++; $display("FAIL mid_celebrate: got %b want 1", celebrate); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (celebrate !== 1'b0) begin errors++; $display("FAIL async_celebrate: got %b want 0", celebrate); end
    checks++; if (freezePlay !== 1'b1) begin errors++; $display("FAIL async_freeze: got %b want 1", freezePlay); end
    checks++; if (winner !== 2'b00 || goalWasScored !== 2'b00) begin errors++; $display("FAIL async_winner_goal: got %b/%b want 00/00", winner, goalWasScored); end
    cyc();
    resetN = 1'b1;
    cyc();
    $display("test_async_reset done");
  endtask

  task automatic test_both_win();
    ourScore = 8'd5;
    oppScore = 8'd7;
    start_match();
    checks++; if (freezePlay !== 1'b0) begin errors++; $display("FAIL both_win_play: got %b want 0", freezePlay); end
    goalDetect = 2'b01;
    cyc();
    goalDetect = 2'b00;
    cyc();
    frames(120);
    checks++; if (gameOver !== 1'b1 || winner !== 2'b01) begin errors++; $display("FAIL both_win_priority: got %b/%b want 1/01", gameOver, winner); end
    $display("test_both_win done");
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    startBtn     = 1'b0;
    goalDetect   = 2'b00;
    ourScore     = 8'd0;
    oppScore     = 8'd0;
    clear_counts();
    test_reset();
    test_start();
    test_no_goal_11();
    test_goal_ours();
    test_game_over_opp();
    test_async_reset();
    test_both_win();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
